// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, baud divisor and width helpers.
// Used by the transmit, receive and echo paths.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per bit, rounded to nearest.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    // Bits needed to hold 'value' (minimum 1).
    function automatic int log2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++)
            if ((value >> i) != 0) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter reloaded on restart, one-cycle tick at zero.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W  = log2(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (restart || cnt == '0)
            cnt <= RELOAD;
        else
            cnt <= cnt - 1'b1;
    end

    // A restart on the same edge starts a fresh period, so it masks the tick.
    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Parity is built only when UART_TX_PARITY_EN is defined.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int clk_freq   = 12_000_000,
    parameter int baud       = 115200,
    parameter int stop_bits  = 1,
    parameter int parity_odd = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);

    localparam int   CPB       = clks_per_bit(clk_freq, baud);
    localparam logic LAST_STOP = (stop_bits == 2);

    if ((stop_bits != 1 && stop_bits != 2) || (parity_odd != 0 && parity_odd != 1)) begin : g_bad_cfg
        $error("uart_tx_unit: stop_bits must be 1 or 2 and parity_odd 0 or 1");
    end

    uart_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        restart, tick;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD = (parity_odd != 0);
    logic par_q, par_d;
`endif

    uart_baud_tick #(.CLKS_PER_BIT(CPB)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        restart    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shreg_d    = tx_data;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    restart    = 1'b1;
                    state_d    = S_START;
`ifdef UART_TX_PARITY_EN
                    // Parity is taken now since the shift register drains the byte.
                    par_d      = (^tx_data) ^ PAR_ODD;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    tx_d    = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit; a line decoder samples each frame mid-bit.
// Build with UART_TX_PARITY_EN defined to exercise parity with two stop bits.
module tb_uart_tx_unit;

    localparam int CPB = 104;
`ifdef UART_TX_PARITY_EN
    localparam int STOP = 2;
    localparam int PB   = 1;
`else
    localparam int STOP = 1;
    localparam int PB   = 0;
`endif
    localparam int F = 9 + PB + STOP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] byte_q[$];
    logic       ok_q[$];
    logic       par_q[$];
    int         rise_q[$];
    logic       busy_d = 1'b0;

    uart_tx_unit #(
        .clk_freq   (12_000_000),
        .baud       (115200),
        .stop_bits  (STOP),
        .parity_odd (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_busy === 1'b1 && !busy_d) rise_q.push_back(cyc);
        busy_d <= (tx_busy === 1'b1);
    end

    // Line decoder: start detected at a negedge, then sampled at bit centres.
    initial begin
        logic [7:0] d;
        logic       ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                ok = (tx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = tx;
                end
                if (PB == 1) begin
                    repeat (CPB) @(negedge clk);
                    par_q.push_back(tx);
                end
                for (int s = 0; s < STOP; s++) begin
                    repeat (CPB) @(negedge clk);
                    ok = ok & (tx === 1'b1);
                end
                byte_q.push_back(d);
                ok_q.push_back(ok);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        byte_q.delete();
        ok_q.delete();
        par_q.delete();
        rise_q.delete();
    endtask

    // Returns one nanosecond after the accepting edge E.
    task automatic send_pulse(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    // Counts cycles with busy high, starting with the current one.
    task automatic wait_idle(output int n);
        n = 0;
        while (tx_busy === 1'b1 && n < 5000) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_activity: got %0d active cycles expected 0", bad); end
        checks++; if (byte_q.size() !== 0) begin errors++; $display("FAIL idle_frames: got %0d frames expected 0", byte_q.size()); end
    endtask

    task automatic test_single();
        int n;
        clear_q();
        send_pulse(8'h41);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL accept_tx: got %b expected 0", tx); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL accept_busy: got %b expected 1", tx_busy); end
        repeat (103) @(posedge clk);
        #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL start_end: got %b expected 0 at E+103", tx); end
        @(posedge clk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL bit0_edge: got %b expected 1 at E+104", tx); end
        wait_idle(n);
        checks++; if (n + 104 !== CPB * F) begin errors++; $display("FAIL busy_len_41: got %0d expected %0d", n + 104, CPB * F); end
        repeat (5) @(posedge clk);
        checks++; if (byte_q.size() !== 1) begin errors++; $display("FAIL frames_41: got %0d expected 1", byte_q.size()); end
        if (byte_q.size() > 0) begin
            checks++; if (byte_q[0] !== 8'h41) begin errors++; $display("FAIL data_41: got %h expected 41", byte_q[0]); end
            checks++; if (ok_q[0] !== 1'b1) begin errors++; $display("FAIL framing_41: got %b expected 1", ok_q[0]); end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        clear_q();
        send_pulse(8'h41);
        repeat (299) @(posedge clk);
        @(negedge clk);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b expected 1", tx_busy); end
        wait_idle(n);
        checks++; if (n + 300 !== CPB * F) begin errors++; $display("FAIL ignore_len: got %0d expected %0d", n + 300, CPB * F); end
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || tx !== 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL ignore_queued: got %0d active cycles expected 0", n); end
        checks++; if (byte_q.size() !== 1) begin errors++; $display("FAIL ignore_frames: got %0d expected 1", byte_q.size()); end
        if (byte_q.size() > 0) begin
            checks++; if (byte_q[0] !== 8'h41) begin errors++; $display("FAIL ignore_data: got %h expected 41", byte_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_q();
        @(negedge clk);
        tx_data  = 8'h0D;
        tx_start = 1'b1;
        n = 0;
        while (rise_q.size() < 3 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        // Changing data during the frame must not affect it.
        tx_data  = 8'hFF;
        tx_start = 1'b0;
        n = 0;
        while (tx_busy === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        checks++; if (rise_q.size() !== 3) begin errors++; $display("FAIL b2b_rises: got %0d expected 3", rise_q.size()); end
        if (rise_q.size() >= 3) begin
            checks++; if (rise_q[1] - rise_q[0] !== CPB * F + 1) begin errors++; $display("FAIL b2b_period1: got %0d expected %0d", rise_q[1] - rise_q[0], CPB * F + 1); end
            checks++; if (rise_q[2] - rise_q[1] !== CPB * F + 1) begin errors++; $display("FAIL b2b_period2: got %0d expected %0d", rise_q[2] - rise_q[1], CPB * F + 1); end
        end
        checks++; if (byte_q.size() !== 3) begin errors++; $display("FAIL b2b_frames: got %0d expected 3", byte_q.size()); end
        for (int i = 0; i < byte_q.size(); i++) begin
            checks++; if (byte_q[i] !== 8'h0D) begin errors++; $display("FAIL b2b_data%0d: got %h expected 0d", i, byte_q[i]); end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int n;
        clear_q();
        send_pulse(8'h07);
        wait_idle(n);
        checks++; if (n !== 1248) begin errors++; $display("FAIL par_busy_len: got %0d expected 1248", n); end
        repeat (5) @(posedge clk);
        checks++; if (byte_q.size() !== 1) begin errors++; $display("FAIL par_frames: got %0d expected 1", byte_q.size()); end
        if (byte_q.size() > 0) begin
            checks++; if (byte_q[0] !== 8'h07) begin errors++; $display("FAIL par_data: got %h expected 07", byte_q[0]); end
            checks++; if (par_q[0] !== 1'b1) begin errors++; $display("FAIL par_bit: got %b expected 1", par_q[0]); end
            checks++; if (ok_q[0] !== 1'b1) begin errors++; $display("FAIL par_stop: got %b expected 1", ok_q[0]); end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        clear_q();
        send_pulse(8'h41);
        repeat (499) @(posedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_pre_tx: got %b expected 0", tx); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", tx_busy); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (1200) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL mid_resume: got %0d active cycles expected 0", n); end
        clear_q();
        send_pulse(8'h3C);
        wait_idle(n);
        checks++; if (n !== CPB * F) begin errors++; $display("FAIL mid_new_len: got %0d expected %0d", n, CPB * F); end
        repeat (5) @(posedge clk);
        checks++; if (byte_q.size() !== 1) begin errors++; $display("FAIL mid_new_frames: got %0d expected 1", byte_q.size()); end
        if (byte_q.size() > 0) begin
            checks++; if (byte_q[0] !== 8'h3C) begin errors++; $display("FAIL mid_new_data: got %h expected 3c", byte_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
